// File: rtl/my_adder.sv
// rtl/my_adder.sv - 16-bit adder stage: sum of two unsigned operands, carry dropped
module my_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    // Plain modulo-2^16 add; callers reconstruct the carry from the operand and sum MSBs
    always_comb begin
        sum = a + b;
    end

endmodule

// File: rtl/my_mul16.sv
// rtl/my_mul16.sv - sequential 16x16 unsigned shift-and-add multiplier with start/busy/done handshake
module my_mul16 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  count;
    logic [15:0] adder_sum;
    logic [15:0] sum;
    logic        cout;

    // The shared 16-bit adder always sees hi + mcand; the multiplier bit decides whether it is used
    my_adder u_adder (
        .a   (hi),
        .b   (mcand),
        .sum (adder_sum)
    );

    // Conditional add for this iteration; carry rebuilt from MSBs since the adder has no carry out
    always_comb begin
        sum  = lo[0] ? adder_sum : hi;
        cout = lo[0] & ((hi[15] & mcand[15]) | ((hi[15] | mcand[15]) & ~sum[15]));
    end

    assign product = {hi, lo};

    // Control FSM and datapath registers; busy/done are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // {cout,sum,lo} shifted right by one, keeping the low 32 bits
                    hi    <= {cout, sum[15:1]};
                    lo    <= {sum[0], lo[15:1]};
                    count <= count + 4'd1;
                    if (count == 4'd15) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_mul16.sv
// tb/tb_my_mul16.sv - self-checking bench for my_mul16
module tb_my_mul16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int errors;
    int checks;

    my_mul16 dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[6];

    // Reference: the product is simply the full-width unsigned arithmetic product
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xx;
        logic [31:0] yy;
        xx = {16'h0, x};
        yy = {16'h0, y};
        return xx * yy;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One accepted multiply from idle; checks latency, busy span, product and single-cycle done
    task automatic run_mul(input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp, input string name);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cycles = 1;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({name, " latency"}, 32'(cycles), 32'd17);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'd16);
        check({name, " product"}, product, exp);
        check({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({name, " product_held"}, product, exp);
    endtask

    initial begin
        int dn;
        int last;
        logic [31:0] got;
        logic [15:0] rx;
        logic [15:0] ry;

        errors = 0;
        checks = 0;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[3] = '{16'h0000, 16'hBEEF, 32'h00000000};
        vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[5] = '{16'h00FF, 16'h0100, 32'h0000FF00};

        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset product", product, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            run_mul(rx, ry, ref_mul(rx, ry), $sformatf("rnd%0d", i));
        end

        // start during RUN must be ignored
        @(negedge clk);
        start = 1'b1; a = 16'd7; b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        got = '0;
        for (int c = 1; c < 45; c++) begin
            if (c == 5) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
            else if (c == 6) begin start = 1'b0; end
            if (done) begin dn++; got = product; end
            @(negedge clk);
        end
        check("ignore product", got, 32'h0000003F);
        check("ignore done_count", 32'(dn), 32'd1);

        // reset mid-run aborts and never pulses done
        @(negedge clk);
        start = 1'b1; a = 16'h00FF; b = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort product", product, 32'd0);
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) dn++;
            @(negedge clk);
        end
        check("abort no_done", 32'(dn), 32'd0);
        run_mul(16'd2, 16'd2, 32'd4, "after_abort");

        // continuous start: 17-cycle cadence, busy low only in DONE
        @(negedge clk);
        start = 1'b1; a = 16'h8000; b = 16'h0002;
        @(negedge clk);
        dn = 0;
        last = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                dn++;
                check($sformatf("cont product%0d", dn), product, 32'h00010000);
                check($sformatf("cont spacing%0d", dn), 32'(c - last), 32'd17);
                last = c;
            end else begin
                checks++;
                if (!busy) begin
                    errors++;
                    $display("FAIL cont busy at cycle %0d: got 0 expected 1", c);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("cont done_count", 32'(dn), 32'd3);
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
